// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port round-robin RAM arbiter.
// Holds the default geometry, requester count and the request record.
package ram_arbiter_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int NUM_REQ    = 2;
  localparam int CNT_W      = 8;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } req_t;

endpackage

// File: rtl/ram_arbiter_simple_ram.sv
// Single-port word memory: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module simple_ram
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester round-robin front end for simple_ram with zero-wait grant,
// one-cycle read response and per-requester accepted-transfer counters.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_W-1:0]              rsp_rdata,
  output logic [NUM_REQ-1:0][CNT_W-1:0]  acc_cnt
);

  logic                           last_gnt;
  logic                           gnt_idx;
  logic                           accept;
  logic                           sel_we;
  logic [ADDR_W-1:0]              sel_addr;
  logic [DATA_W-1:0]              sel_wdata;
  logic [DATA_W-1:0]              ram_rdata;
  logic [NUM_REQ-1:0]             rsp_valid_q;
  logic [DATA_W-1:0]              rsp_rdata_q;
  logic [NUM_REQ-1:0][CNT_W-1:0]  cnt_q;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    req_ready = '0;
    if (!rst) begin
      if (req_valid == 2'b11) req_ready = last_gnt ? 2'b01 : 2'b10;
      else                    req_ready = req_valid;
    end
  end

  assign accept    = |req_ready;
  assign gnt_idx   = req_ready[1];
  assign sel_we    = req_we[gnt_idx];
  assign sel_addr  = req_addr[gnt_idx];
  assign sel_wdata = req_wdata[gnt_idx];

  simple_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (accept & sel_we),
    .addr  (sel_addr),
    .wdata (sel_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt    <= 1'b1;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      rsp_valid_q <= (accept && !sel_we) ? req_ready : '0;
      if (accept && !sel_we) rsp_rdata_q <= ram_rdata;
      if (accept) begin
        last_gnt       <= gnt_idx;
        cnt_q[gnt_idx] <= cnt_q[gnt_idx] + CNT_W'(1);
      end
    end
  end

  // Reset masks the registered outputs immediately so a response due in the reset cycle is dropped.
  assign rsp_valid = rst ? '0 : rsp_valid_q;
  assign rsp_rdata = rst ? '0 : rsp_rdata_q;
  assign acc_cnt   = rst ? '0 : cnt_q;

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 4, SHALL set the memory address width (depth = 2**ADDR_W = 16 words).
REQ-002 Parameter DATA_W, default 8, SHALL set the memory word width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 req_valid  input  2  SHALL be the per-requester request valid; bit i belongs to requester i.
REQ-006 req_ready  output  2  SHALL be the per-requester request accept, one-hot or zero.
REQ-007 req_we  input  2  SHALL select write (1) or read (0) per requester.
REQ-008 req_addr  input  2xADDR_W  SHALL be the per-requester word address.
REQ-009 req_wdata  input  2xDATA_W  SHALL be the per-requester write data.
REQ-010 rsp_valid  output  2  SHALL be the per-requester read-response strobe.
REQ-011 rsp_rdata  output  DATA_W  SHALL be the shared read data, qualified by rsp_valid.
REQ-012 acc_cnt  output  2x8  SHALL hold per-requester accepted-transfer counters.

Function
REQ-013 A transfer on requester i SHALL be accepted in a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-014 req_ready SHALL be combinational from req_valid and the priority pointer, at most one bit high, and never high without the matching req_valid.
REQ-015 With one requester valid, that requester SHALL be granted in the same cycle (zero-wait).
REQ-016 With both valid, the requester not named by the last-grant pointer SHALL win (round-robin).
REQ-017 The last-grant pointer SHALL update to the winner on every accepted transfer and SHALL hold otherwise.
REQ-018 An accepted write SHALL commit req_wdata to mem[req_addr] at the accepting clock edge.
REQ-019 An accepted read SHALL assert rsp_valid[i] exactly one cycle later for one cycle; rsp_rdata SHALL carry mem[addr] as sampled in the accept cycle.
REQ-020 Responses SHALL have no backpressure; back-to-back reads SHALL give back-to-back rsp_valid pulses.
REQ-021 A read accepted the cycle after a write to the same address SHALL return the new data.
REQ-022 rsp_rdata SHALL hold its last value when rsp_valid is 0.
REQ-023 req_addr, req_we and req_wdata SHALL be ignored for requesters not granted.
REQ-024 acc_cnt[i] SHALL increment by 1 per accepted transfer on i and wrap 255 -> 0.
REQ-025 A waiting requester SHALL be granted within 2 cycles while it holds req_valid (no starvation).

Reset
REQ-026 During rst: req_ready = 0, rsp_valid = 0, rsp_rdata = 0, acc_cnt = 0, pointer = 1 (requester 0 wins the first tie).
REQ-027 rst asserted mid-operation SHALL drop any response due next cycle and SHALL block writes in that cycle.
REQ-028 Memory contents SHALL NOT be reset.

Structure
REQ-029 A shared package SHALL hold ADDR_W and DATA_W defaults, NUM_REQ = 2, and the request struct typedef (we, addr, wdata).
REQ-030 Storage SHALL be the existing simple_ram (sync write, async read) as the one sub-module; arbitration, response register and counters SHALL live in ram_arbiter.

Verification
REQ-031 Single write/read: req0 write addr 3 data 0xA5, then req0 read addr 3 -> rsp_valid[0] one cycle after accept, rsp_rdata 0xA5.
REQ-032 First tie after reset: both valid reads -> req_ready = 01, then next cycle 10; sustained contention alternates 01/10.
REQ-033 Contention on one address: req0 write addr 7 = 0x3C, req1 read addr 7 in the same cycle -> req0 first, req1 accepted next cycle, reads 0x3C.
REQ-034 Back-to-back reads by req1 of addr 0,1,2 preloaded 0x10/0x11/0x12 -> rsp_valid[1] high 3 consecutive cycles, data 0x10, 0x11, 0x12.
REQ-035 Reset mid-read: rst in the cycle after read accept -> no rsp_valid, acc_cnt = 0; memory retains prior data.
REQ-036 Counter wrap: 256 accepted transfers on req0 -> acc_cnt[0] returns to 0; acc_cnt[1] unchanged.
